// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 INCR-only memory slave with independent write/read FSMs over a dual-port RAM.
module axi_ram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    localparam int AW = $clog2(DEPTH);
    localparam int WA = ADDR_W - 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    logic        unused_addr_lsbs;

    w_state_t    w_state, w_next;
    logic [WA-1:0] w_addr;
    logic [7:0]  w_len;
    logic [8:0]  w_cnt;
    logic        w_cfg_err, w_slv, w_dec;
    logic        aw_hs, w_hs, b_hs, w_in_range, w_late, w_short, w_we;

    r_state_t    r_state, r_next;
    logic [WA-1:0] r_addr, rd_addr;
    logic [7:0]  r_len, r_cnt;
    logic        r_cfg_err, r_ok, ar_hs, r_hs, rd_en, rd_cfg;
    logic [1:0]  rd_resp;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs      = s_axi_awvalid & s_axi_awready;
    assign w_hs       = s_axi_wvalid & s_axi_wready;
    assign b_hs       = s_axi_bvalid & s_axi_bready;
    assign w_in_range = 32'(w_addr) < DEPTH;
    assign w_late     = w_cnt > {1'b0, w_len};
    assign w_short    = s_axi_wlast & (w_cnt != {1'b0, w_len});
    assign w_we       = w_hs & ~w_cfg_err & w_in_range & ~w_late;

    always_comb begin
        w_next = aw_hs ? W_DATA : (w_hs & s_axi_wlast) ? W_RESP : b_hs ? W_IDLE : w_state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_cfg_err     <= 1'b0;
            w_slv         <= 1'b0;
            w_dec         <= 1'b0;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= w_next == W_IDLE;
            s_axi_wready  <= w_next == W_DATA;
            s_axi_bvalid  <= w_next == W_RESP;
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                w_addr    <= s_axi_awaddr[ADDR_W-1:2];
                w_len     <= s_axi_awlen;
                w_cnt     <= '0;
                w_cfg_err <= (s_axi_awsize != 3'b010) || (s_axi_awburst != 2'b01);
                w_slv     <= 1'b0;
                w_dec     <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_addr + WA'(1);
                w_cnt  <= w_cnt + 9'(w_cnt != 9'h1ff);
                w_dec  <= w_dec | ~w_in_range;
                w_slv  <= w_slv | w_late | w_short;
            end
            // DECERR outranks SLVERR; the current beat's flags are folded in directly
            if (w_hs && s_axi_wlast)
                s_axi_bresp <= (w_dec | ~w_in_range) ? 2'b11 :
                               (w_cfg_err | w_slv | w_late | w_short) ? 2'b10 : 2'b00;
        end
    end

    assign ar_hs   = s_axi_arvalid & s_axi_arready;
    assign r_hs    = s_axi_rvalid & s_axi_rready;
    assign rd_en   = ar_hs | (r_hs & ~s_axi_rlast);
    assign rd_addr = ar_hs ? s_axi_araddr[ADDR_W-1:2] : r_addr + WA'(1);
    assign rd_cfg  = ar_hs ? ((s_axi_arsize != 3'b010) || (s_axi_arburst != 2'b01)) : r_cfg_err;
    assign rd_resp = rd_cfg ? 2'b10 : (32'(rd_addr) >= DEPTH) ? 2'b11 : 2'b00;
    assign s_axi_rdata = r_ok ? rd_q : 32'h0;

    always_comb begin
        r_next = ar_hs ? R_DATA : (r_hs & s_axi_rlast) ? R_IDLE : r_state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= 2'b00;
            s_axi_rlast   <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_cfg_err     <= 1'b0;
            r_ok          <= 1'b0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= r_next == R_IDLE;
            s_axi_rvalid  <= r_next == R_DATA;
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                r_len     <= s_axi_arlen;
                r_cfg_err <= rd_cfg;
            end
            // response fields advance together with the RAM read, so they stay put under backpressure
            if (rd_en) begin
                r_addr      <= rd_addr;
                s_axi_rresp <= rd_resp;
                r_ok        <= rd_resp == 2'b00;
                s_axi_rlast <= ar_hs ? (s_axi_arlen == 8'd0) : (r_cnt + 8'd1 == r_len);
                r_cnt       <= ar_hs ? 8'd0 : r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we)
            for (int i = 0; i < 4; i++)
                if (s_axi_wstrb[i]) mem[w_addr[AW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        if (rd_en) rd_q <= mem[rd_addr[AW-1:0]];
    end
endmodule
